// File: rtl/fir_tap_sequencer.sv
// Per-sample tap sequencer for the band-stop filter MAC: keeps a circular sample
// history and coefficient bank, streams NTAPS (sample, coeff) pairs, then returns the result.
module fir_tap_sequencer #(
  parameter int NTAPS    = 8,
  parameter int DW       = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [DW-1:0]            coef_wdata,
  output logic                     coef_err,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            m_data,
  output logic                     m_ovf,
  output logic                     filt_clr,
  output logic                     filt_enable,
  output logic [DW-1:0]            filt_data,
  output logic [DW-1:0]            filt_coeff,
  input  logic [DW-1:0]            filt_result,
  input  logic                     filt_overflow,
  output logic                     busy
);
  localparam int AW = $clog2(NTAPS);
  localparam int CW = $clog2(PIPE_LAT + 1);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, cur_q, cur_d, tap_q, tap_d, rd_idx;
  logic [CW-1:0]   drain_q, drain_d;
  logic            ovf_q, ovf_d, m_ovf_q, m_ovf_d, coef_err_q, coef_err_d;
  logic            filt_clr_q, filt_clr_d, filt_enable_q, filt_enable_d;
  logic [DW-1:0]   m_data_q, m_data_d, filt_data_q, filt_data_d, filt_coeff_q, filt_coeff_d;
  logic [DW-1:0]   hist_q [NTAPS];
  logic [DW-1:0]   hist_d [NTAPS];
  logic [DW-1:0]   coef_q [NTAPS];
  logic [DW-1:0]   coef_d [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (s_valid) state_d = S_CLR;
      S_CLR:   state_d = S_ISSUE;
      S_ISSUE: if (tap_q == LAST_TAP) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == ONE_C) state_d = S_OUT;
      S_OUT:   if (m_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == S_IDLE);
    busy    = (state_q == S_CLR) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    m_valid = (state_q == S_OUT);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cur_d      = cur_q;
    tap_d      = tap_q;
    drain_d    = drain_q;
    ovf_d      = ovf_q;
    m_data_d   = m_data_q;
    m_ovf_d    = m_ovf_q;
    hist_d     = hist_q;
    coef_d     = coef_q;
    coef_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (s_valid) begin
        hist_d[wr_ptr_q] = s_data;
        cur_d            = wr_ptr_q;
        wr_ptr_d         = wr_ptr_q + ONE_A;
      end
      S_CLR: begin
        ovf_d = 1'b0;
        tap_d = '0;
      end
      S_ISSUE: begin
        ovf_d = ovf_q | filt_overflow;
        tap_d = tap_q + ONE_A;
        if (tap_q == LAST_TAP) drain_d = CW'(PIPE_LAT);
      end
      S_DRAIN: begin
        ovf_d   = ovf_q | filt_overflow;
        drain_d = drain_q - ONE_C;
        if (drain_q == ONE_C) begin
          m_data_d = filt_result;
          m_ovf_d  = ovf_q | filt_overflow;
        end
      end
      default: ;
    endcase
    // Coefficients are frozen for the whole CLR..DRAIN run so one result never mixes banks.
    if (coef_we) begin
      if ((state_q == S_IDLE) || (state_q == S_OUT)) coef_d[coef_addr] = coef_wdata;
      else coef_err_d = 1'b1;
    end
  end

  // Filter outputs are registered from the upcoming state so they line up with it.
  always_comb begin
    rd_idx        = cur_q - tap_d;
    filt_clr_d    = (state_d == S_CLR);
    filt_enable_d = (state_d == S_ISSUE);
    filt_data_d   = filt_enable_d ? hist_q[rd_idx] : '0;
    filt_coeff_d  = filt_enable_d ? coef_q[tap_d]  : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      cur_q         <= '0;
      tap_q         <= '0;
      drain_q       <= '0;
      ovf_q         <= 1'b0;
      m_data_q      <= '0;
      m_ovf_q       <= 1'b0;
      coef_err_q    <= 1'b0;
      filt_clr_q    <= 1'b0;
      filt_enable_q <= 1'b0;
      filt_data_q   <= '0;
      filt_coeff_q  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      cur_q         <= cur_d;
      tap_q         <= tap_d;
      drain_q       <= drain_d;
      ovf_q         <= ovf_d;
      m_data_q      <= m_data_d;
      m_ovf_q       <= m_ovf_d;
      coef_err_q    <= coef_err_d;
      filt_clr_q    <= filt_clr_d;
      filt_enable_q <= filt_enable_d;
      filt_data_q   <= filt_data_d;
      filt_coeff_q  <= filt_coeff_d;
      hist_q        <= hist_d;
      coef_q        <= coef_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_ovf       = m_ovf_q;
  assign coef_err    = coef_err_q;
  assign filt_clr    = filt_clr_q;
  assign filt_enable = filt_enable_q;
  assign filt_data   = filt_data_q;
  assign filt_coeff  = filt_coeff_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed vector table, corner sequences and random runs
// checked against a sample-list / coefficient-array model and a simple MAC filter stand-in.
module tb_fir_tap_sequencer;
  localparam int NTAPS = 8;
  localparam int DW = 16;
  localparam int PIPE_LAT = 2;
  localparam int AW = $clog2(NTAPS);

  logic clk = 1'b0;
  logic rst_n, coef_we, coef_err, s_valid, s_ready, m_valid, m_ready, m_ovf;
  logic filt_clr, filt_enable, filt_overflow, busy;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_wdata, s_data, m_data, filt_data, filt_coeff, filt_result;

  fir_tap_sequencer #(.NTAPS(NTAPS), .DW(DW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf),
    .filt_clr(filt_clr), .filt_enable(filt_enable), .filt_data(filt_data),
    .filt_coeff(filt_coeff), .filt_result(filt_result), .filt_overflow(filt_overflow),
    .busy(busy));

  always #5 clk = ~clk;

  // Stand-in filter: accumulate enabled products, one extra output register.
  logic [DW-1:0] f_acc = '0, f_res = '0;
  always @(posedge clk) begin
    if (filt_clr) f_acc <= '0;
    else if (filt_enable) f_acc <= DW'(f_acc + filt_data * filt_coeff);
    f_res <= f_acc;
  end
  assign filt_result = f_res;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] smp [$];
  logic [DW-1:0] coef_m [NTAPS];
  logic [DW-1:0] last_taps [NTAPS];
  logic [DW-1:0] last_coefs [NTAPS];
  logic [DW-1:0] last_m_data;
  logic last_m_ovf;

  typedef struct {
    logic [DW-1:0] x;
    int            ovf_idx;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] hist_at(input int k);
    if (k < smp.size()) return smp[smp.size() - 1 - k];
    return '0;
  endfunction

  task automatic clear_model();
    smp.delete();
    for (int i = 0; i < NTAPS; i++) coef_m[i] = '0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
    coef_m[a] = d;
    chk("coef_err_idle_write", 32'(coef_err), 32'd0);
  endtask

  // One full transaction, entered and left at a negedge with the DUT in IDLE.
  task automatic run_sample(input logic [DW-1:0] x, input int ovf_idx, input int hold,
                            input bit busy_wr, input bit out_wr,
                            input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    logic [DW-1:0] exp_d;
    logic exp_o;
    int t = 0;
    while (!s_ready && t < 50) begin @(negedge clk); t++; end
    chk("s_ready_before_accept", 32'(s_ready), 32'd1);
    smp.push_back(x);
    exp_d = '0;
    for (int k = 0; k < NTAPS; k++) exp_d = DW'(exp_d + hist_at(k) * coef_m[k]);
    exp_o = (ovf_idx >= 0) && (ovf_idx < NTAPS + PIPE_LAT);
    s_valid = 1'b1; s_data = x;
    @(negedge clk);
    s_valid = 1'b0; s_data = DW'($urandom);
    chk("clr_cycle_filt_clr", 32'(filt_clr), 32'd1);
    chk("clr_cycle_filt_enable", 32'(filt_enable), 32'd0);
    chk("clr_cycle_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NTAPS; k++) begin
      @(negedge clk);
      filt_overflow = (ovf_idx == k);
      last_taps[k]  = filt_data;
      last_coefs[k] = filt_coeff;
      chk("issue_filt_enable", 32'(filt_enable), 32'd1);
      chk("issue_filt_clr", 32'(filt_clr), 32'd0);
      chk("issue_filt_data", 32'(filt_data), 32'(hist_at(k)));
      chk("issue_filt_coeff", 32'(filt_coeff), 32'(coef_m[k]));
      coef_we = 1'b0;
      if (busy_wr && k == 2) begin coef_we = 1'b1; coef_addr = waddr; coef_wdata = wdata; end
      if (busy_wr && k == 3) chk("coef_err_pulse", 32'(coef_err), 32'd1);
      if (busy_wr && k == 4) chk("coef_err_single", 32'(coef_err), 32'd0);
    end
    for (int d = 0; d < PIPE_LAT; d++) begin
      @(negedge clk);
      coef_we = 1'b0;
      filt_overflow = (ovf_idx == NTAPS + d);
      chk("drain_filt_enable", 32'(filt_enable), 32'd0);
      chk("drain_m_valid", 32'(m_valid), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    filt_overflow = 1'b0;
    last_m_data = m_data;
    last_m_ovf  = m_ovf;
    chk("out_m_valid_at_latency", 32'(m_valid), 32'd1);
    chk("out_m_data", 32'(m_data), 32'(exp_d));
    chk("out_m_ovf", 32'(m_ovf), 32'(exp_o));
    chk("out_busy", 32'(busy), 32'd0);
    chk("out_s_ready", 32'(s_ready), 32'd0);
    if (out_wr) begin coef_we = 1'b1; coef_addr = waddr; coef_wdata = wdata; end
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'b1; s_data = DW'($urandom);
      @(negedge clk);
      coef_we = 1'b0;
      chk("hold_m_valid", 32'(m_valid), 32'd1);
      chk("hold_m_data", 32'(m_data), 32'(exp_d));
      chk("hold_m_ovf", 32'(m_ovf), 32'(exp_o));
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_filt_enable", 32'(filt_enable), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    coef_we = 1'b0;
    chk("after_handshake_s_ready", 32'(s_ready), 32'd1);
    chk("after_handshake_m_valid", 32'(m_valid), 32'd0);
    if (out_wr) begin
      chk("coef_err_out_write", 32'(coef_err), 32'd0);
      coef_m[waddr] = wdata;
    end
  endtask

  initial begin
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; filt_overflow = 1'b0;
    clear_model();
    // Newest-first history with coef[k]=k+1, sums truncated to DW bits.
    tbl[0] = '{x: 16'h0001, ovf_idx: -1, exp_data: 16'h0001, exp_ovf: 1'b0};
    tbl[1] = '{x: 16'h0000, ovf_idx: -1, exp_data: 16'h0002, exp_ovf: 1'b0};
    tbl[2] = '{x: 16'h0002, ovf_idx:  3, exp_data: 16'h0005, exp_ovf: 1'b1};
    tbl[3] = '{x: 16'h0003, ovf_idx: -1, exp_data: 16'h000B, exp_ovf: 1'b0};
    tbl[4] = '{x: 16'hFFFF, ovf_idx: -1, exp_data: 16'h0010, exp_ovf: 1'b0};
    tbl[5] = '{x: 16'h0000, ovf_idx:  9, exp_data: 16'h0015, exp_ovf: 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_filt_enable", 32'(filt_enable), 32'd0);
    chk("rst_filt_clr", 32'(filt_clr), 32'd0);
    chk("rst_filt_data", 32'(filt_data), 32'd0);
    chk("rst_filt_coeff", 32'(filt_coeff), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_ovf", 32'(m_ovf), 32'd0);
    chk("rst_coef_err", 32'(coef_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), DW'(k + 1));
    for (int i = 0; i < 6; i++) begin
      run_sample(tbl[i].x, tbl[i].ovf_idx, 0, 1'b0, 1'b0, '0, '0);
      chk("tbl_m_data", 32'(last_m_data), 32'(tbl[i].exp_data));
      chk("tbl_m_ovf", 32'(last_m_ovf), 32'(tbl[i].exp_ovf));
    end

    run_sample(16'h0123, -1, 5, 1'b0, 1'b0, '0, '0);
    run_sample(16'h0042, -1, 0, 1'b1, 1'b0, AW'(3), 16'h7FFF);
    chk("busy_write_dropped", 32'(last_coefs[3]), 32'd4);
    run_sample(16'h0007, -1, 0, 1'b0, 1'b0, '0, '0);
    chk("busy_write_next_run", 32'(last_coefs[3]), 32'd4);
    write_coef(AW'(3), 16'h7FFF);
    run_sample(16'h0009, -1, 0, 1'b0, 1'b0, '0, '0);
    chk("idle_write_applied", 32'(last_coefs[3]), 32'h7FFF);

    // Reset while taps are streaming.
    s_valid = 1'b1; s_data = 16'h0055;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_issue_enable", 32'(filt_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_filt_enable", 32'(filt_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
    chk("mid_rst_filt_data", 32'(filt_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    run_sample(16'h0001, -1, 0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k < NTAPS; k++) chk("post_rst_hist_clear", 32'(last_taps[k]), 32'd0);

    reset_pulse();
    for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), DW'(k + 1));
    for (int i = 1; i <= 10; i++) run_sample(DW'(i), -1, 0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < NTAPS; k++) chk("wrap_filt_data", 32'(last_taps[k]), 32'(10 - k));
    chk("wrap_wr_ptr", 32'(dut.wr_ptr_q), 32'd2);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(AW'($urandom), DW'($urandom));
      run_sample(DW'($urandom), int'($urandom_range(0, 13)) - 2, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
